// File: rtl/o_serdes_pkg.sv
// ============================================================================
// o_serdes_pkg : shared types and helpers for the o_serdes_tx serializer
// Rev 1.0
// ============================================================================
`default_nettype none

package o_serdes_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int MODE_SDR = 0;
  localparam int MODE_DDR = 1;

  // Number of clock periods needed to shift out one parallel word.
  function automatic int beats(input int width, input int ddr_mode);
    return (ddr_mode == MODE_DDR) ? (width / 2) : width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/o_ddr_cell.sv
// ============================================================================
// o_ddr_cell : pad-side output flops and clock-phase mux (DDR or SDR)
// Rev 1.0
// ============================================================================
`default_nettype none

module o_ddr_cell #(
  parameter int   BPB        = 2,
  parameter bit   NEG_EN     = 1'b1,
  parameter logic IDLE_VALUE = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [BPB-1:0] pos_d,
  output logic           q
);

  logic [BPB-1:0] pos_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= {BPB{IDLE_VALUE}};
    end else if (en) begin
      pos_q <= pos_d;
    end
  end

  generate
    if (NEG_EN) begin : g_neg
      logic neg_q;

      // Retime the second bit of the beat so it is stable across the low phase.
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          neg_q <= IDLE_VALUE;
        end else if (en) begin
          neg_q <= pos_q[BPB-1];
        end
      end

      assign q = clk ? pos_q[0] : neg_q;
    end else begin : g_pos_only
      assign q = pos_q[0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/o_serdes_tx.sv
// ============================================================================
// o_serdes_tx : WIDTH:1 / WIDTH:2 output serializer, LSB first, valid/ready in
// Rev 1.0  -- optional link-training pattern under O_SERDES_TX_TRAINING_EN
// ============================================================================
`default_nettype none

module o_serdes_tx
  import o_serdes_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   DDR_MODE   = 1,
  parameter logic IDLE_VALUE = 1'b0
`ifdef O_SERDES_TX_TRAINING_EN
  ,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = {(WIDTH/2){2'b10}}
`endif
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
`ifdef O_SERDES_TX_TRAINING_EN
  input  logic             TRAIN,
`endif
  output logic             DR,
  output logic             Q,
  output logic             OE,
  output logic             UNDERRUN
);

  localparam int BEATS = beats(WIDTH, DDR_MODE);
  localparam int BPB   = (DDR_MODE == MODE_DDR) ? 2 : 1;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] shifter, shifter_nx;
  logic [WIDTH-1:0] load_word;
  logic [BPB-1:0]   pos_d;
  logic             oe_nx, underrun_nx;
  logic             empty, load;

  assign empty = (cnt == '0);

`ifdef O_SERDES_TX_TRAINING_EN
  // Training pre-empts the fabric: pattern words load whenever the shifter drains.
  assign load_word = TRAIN ? TRAIN_PATTERN : D;
  assign load      = TRAIN | DV;
  assign DR        = E & empty & ~R & ~TRAIN;
`else
  assign load_word = D;
  assign load      = DV;
  assign DR        = E & empty & ~R;
`endif

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    shifter_nx  = shifter;
    oe_nx       = OE;
    underrun_nx = 1'b0;
    pos_d       = {BPB{IDLE_VALUE}};
    if (!empty) begin
      pos_d      = shifter[BPB-1:0];
      shifter_nx = shifter >> BPB;
      cnt_nx     = cnt - CW'(1);
    end else if (load) begin
      pos_d      = load_word[BPB-1:0];
      shifter_nx = load_word >> BPB;
      cnt_nx     = LAST_CNT;
      state_nx   = ACTIVE;
      oe_nx      = 1'b1;
    end else begin
      state_nx    = IDLE;
      oe_nx       = 1'b0;
      underrun_nx = (state == ACTIVE);
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state    <= IDLE;
      cnt      <= '0;
      shifter  <= '0;
      OE       <= 1'b0;
      UNDERRUN <= 1'b0;
    end else if (E) begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      shifter  <= shifter_nx;
      OE       <= oe_nx;
      UNDERRUN <= underrun_nx;
    end
  end

  o_ddr_cell #(
    .BPB        (BPB),
    .NEG_EN     (DDR_MODE == MODE_DDR),
    .IDLE_VALUE (IDLE_VALUE)
  ) u_cell (
    .clk   (C),
    .rst   (R),
    .en    (E),
    .pos_d (pos_d),
    .q     (Q)
  );

endmodule

`default_nettype wire

// File: tb/tb_o_serdes_tx.sv
// ============================================================================
// tb_o_serdes_tx : DDR (WIDTH=8) and SDR (WIDTH=4) instances vs. a bit-queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_o_serdes_tx;

  logic       C = 1'b0;
  logic       R, E;
  logic [7:0] d_a;
  logic       dv_a, dr_a, q_a, oe_a, un_a;
  logic [3:0] d_b;
  logic       dv_b, dr_b, q_b, oe_b, un_b;
`ifdef O_SERDES_TX_TRAINING_EN
  logic       train = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  // Model: pending serial bits per instance, bits of the current period, flags.
  bit         qa[$];
  bit         qb[$];
  logic [1:0] m_cur_a;
  logic       m_cur_b;
  logic       m_oe_a, m_oe_b, m_un_a, m_un_b;
  logic       acc_a, acc_b;

  always #5 C = ~C;

  o_serdes_tx #(.WIDTH(8), .DDR_MODE(1), .IDLE_VALUE(1'b0)) dut_a (
    .C(C), .R(R), .E(E), .D(d_a), .DV(dv_a),
`ifdef O_SERDES_TX_TRAINING_EN
    .TRAIN(train),
`endif
    .DR(dr_a), .Q(q_a), .OE(oe_a), .UNDERRUN(un_a)
  );

  o_serdes_tx #(.WIDTH(4), .DDR_MODE(0), .IDLE_VALUE(1'b0)) dut_b (
    .C(C), .R(R), .E(E), .D(d_b), .DV(dv_b),
`ifdef O_SERDES_TX_TRAINING_EN
    .TRAIN(train),
`endif
    .DR(dr_b), .Q(q_b), .OE(oe_b), .UNDERRUN(un_b)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    m_cur_a = 2'b00; m_cur_b = 1'b0;
    m_oe_a  = 1'b0;  m_oe_b  = 1'b0;
    m_un_a  = 1'b0;  m_un_b  = 1'b0;
    acc_a   = 1'b0;  acc_b   = 1'b0;
  endtask

  // One clock period; entered and left in the low phase with inputs stable.
  task automatic cycle();
    logic xa, xb;
    xa = E && !R && (qa.size() == 0);
    xb = E && !R && (qb.size() == 0);
    #1;
    chk("dr_a", dr_a, xa);
    chk("dr_b", dr_b, xb);
    @(posedge C);
    acc_a = 1'b0;
    acc_b = 1'b0;
    if (E && !R) begin
      if (dv_a && xa) begin
        acc_a = 1'b1;
        for (int i = 0; i < 8; i++) qa.push_back(d_a[i]);
      end
      if (qa.size() != 0) begin
        m_cur_a[0] = qa.pop_front();
        m_cur_a[1] = qa.pop_front();
        m_oe_a = 1'b1; m_un_a = 1'b0;
      end else begin
        m_cur_a = 2'b00; m_un_a = m_oe_a; m_oe_a = 1'b0;
      end
      if (dv_b && xb) begin
        acc_b = 1'b1;
        for (int i = 0; i < 4; i++) qb.push_back(d_b[i]);
      end
      if (qb.size() != 0) begin
        m_cur_b = qb.pop_front();
        m_oe_b = 1'b1; m_un_b = 1'b0;
      end else begin
        m_cur_b = 1'b0; m_un_b = m_oe_b; m_oe_b = 1'b0;
      end
    end
    #2;
    chk("q_a_high", q_a, m_cur_a[0]);
    chk("oe_a", oe_a, m_oe_a);
    chk("underrun_a", un_a, m_un_a);
    chk("q_b_high", q_b, m_cur_b);
    chk("oe_b", oe_b, m_oe_b);
    chk("underrun_b", un_b, m_un_b);
    @(negedge C);
    #2;
    chk("q_a_low", q_a, m_cur_a[1]);
    chk("q_b_low", q_b, m_cur_b);
  endtask

  // Asynchronous reset pulse; outputs must collapse immediately.
  task automatic reset_pulse();
    R = 1'b1;
    #1;
    chk("rst_q_a", q_a, 1'b0);
    chk("rst_oe_a", oe_a, 1'b0);
    chk("rst_dr_a", dr_a, 1'b0);
    chk("rst_un_a", un_a, 1'b0);
    chk("rst_q_b", q_b, 1'b0);
    chk("rst_oe_b", oe_b, 1'b0);
    chk("rst_dr_b", dr_b, 1'b0);
    @(posedge C);
    #2;
    chk("rst_q_a_high", q_a, 1'b0);
    chk("rst_un_a_high", un_a, 1'b0);
    chk("rst_un_b_high", un_b, 1'b0);
    @(negedge C);
    #2;
    R = 1'b0;
    model_clear();
  endtask

  initial begin
    int idx;
    logic [7:0] words [2];
    R = 1'b0; E = 1'b1;
    d_a = 8'h00; dv_a = 1'b0;
    d_b = 4'h0;  dv_b = 1'b0;
    model_clear();
    @(negedge C);
    #2;
    reset_pulse();

    // Single DDR word plus single SDR word, then let both streams underrun.
    d_a = 8'hA5; dv_a = 1'b1;
    d_b = 4'hC;  dv_b = 1'b1;
    cycle();
    dv_a = 1'b0; dv_b = 1'b0;
    repeat (6) cycle();

    // Back-to-back words with DV held.
    words[0] = 8'hA5; words[1] = 8'h3C;
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      if (idx < 2) begin
        dv_a = 1'b1; d_a = words[idx];
      end else begin
        dv_a = 1'b0;
      end
      cycle();
      if (acc_a) idx++;
    end

    // Clock-enable freeze after the second beat.
    d_a = 8'hF0; dv_a = 1'b1;
    cycle();
    dv_a = 1'b0;
    cycle();
    E = 1'b0;
    repeat (3) cycle();
    E = 1'b1;
    repeat (4) cycle();

    // Reset in the middle of a word, then a fresh word.
    d_a = 8'h5A; dv_a = 1'b1;
    cycle();
    dv_a = 1'b0;
    cycle();
    reset_pulse();
    d_a = 8'h81; dv_a = 1'b1;
    cycle();
    dv_a = 1'b0;
    repeat (5) cycle();

    // Randomized traffic with gaps, enable drops and occasional resets.
    dv_a = 1'b0; dv_b = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!dv_a || acc_a) begin
        dv_a = ($urandom_range(0, 9) < 7);
        d_a  = 8'($urandom);
      end
      if (!dv_b || acc_b) begin
        dv_b = ($urandom_range(0, 9) < 6);
        d_b  = 4'($urandom);
      end
      E = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 149) == 0) reset_pulse();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/o_serdes_tx.md
Name: o_serdes_tx

Overview:
- Parametrised output serializer; successor to the fixed 2:1 output DDR cell.
- Accepts a WIDTH-bit parallel word over a valid/ready handshake and drives it LSB-first on one pad-side output.
- Drives 2 bits per clock in DDR mode or 1 bit per clock in SDR mode.
- Sits between fabric-side TX logic and the output buffer; flags gaps in streaming.

Parameters:
- WIDTH, 8, parallel word width; legal 2..16; must be even when DDR_MODE=1.
- DDR_MODE, 1, 1 = two bits per C period (high phase then low phase); 0 = one bit per C period.
- IDLE_VALUE, 1'b0, level driven on Q when no word is active and during reset.

Ports:
- C  input  1  clock; the only clock; DDR uses both edges.
- R  input  1  reset; asynchronous, active-high.
- E  input  1  clock enable; low freezes all state.
- D  input  WIDTH  parallel word.
- DV  input  1  D valid.
- DR  output  1  ready; word accepted on posedge C when DV&DR.
- Q  output  1  serial data.
- OE  output  1  high while Q carries word bits.
- UNDERRUN  output  1  one-cycle pulse: stream ended with no next word.

Behaviour:
- BEATS = WIDTH/2 (DDR) or WIDTH (SDR). cnt = beats still held in the shifter; width is clog2(BEATS).
- States: IDLE, ACTIVE.
- Reset (R=1, async): state IDLE, cnt 0, shifter 0, pos_q = {IDLE_VALUE,IDLE_VALUE}, neg_q = IDLE_VALUE, OE 0, UNDERRUN 0. Q = IDLE_VALUE. DR = 0 while R is high.
- DR = E & (cnt==0) & !R. This is combinational and allows gap-free streaming.
- Posedge C with E=1:
  - cnt!=0: pos_q <= next beat from shifter; shifter >>= bits/beat; cnt--. OE stays 1.
  - cnt==0 and DV: pos_q <= D[1:0] (DDR) or D[0] (SDR); shifter <= D >> bits/beat; cnt <= BEATS-1; state ACTIVE; OE <= 1.
  - cnt==0, !DV, state ACTIVE: UNDERRUN <= 1 for one cycle; state IDLE; OE <= 0; pos_q <= IDLE_VALUE.
  - cnt==0, !DV, state IDLE: pos_q <= IDLE_VALUE; OE 0.
  - UNDERRUN <= 0 in every case except the ACTIVE-underrun case above.
- Negedge C with E=1 (DDR only): neg_q <= pos_q[1].
- Output mux:
  - DDR: Q = C ? pos_q[0] : neg_q.
  - SDR: Q = pos_q[0] for the whole period; neg_q is unused and has no negedge flop.
- Latency: bit D[0] appears on Q in the high phase immediately after the accepting posedge. In DDR, D[1] appears in the following low phase.
- Throughput: one word per BEATS cycles when DV is held high. DR is high for exactly one cycle per word.
- E=0: no register updates on either edge and DR=0. Q and OE hold their values. The sequence resumes where it stopped once E=1.
- Reset mid-word: the word is discarded and no UNDERRUN is raised. After R falls, the first word is accepted at the first posedge with DV&E.
- DV while DR=0 is ignored; the source must hold D stable until accepted.

Optional Feature:
- Macro O_SERDES_TX_TRAINING_EN.
- When defined:
  - Adds input TRAIN (1 bit) and parameter TRAIN_PATTERN (WIDTH bits, default alternating 1010...).
  - While TRAIN=1 and cnt==0, TRAIN_PATTERN is loaded instead of D; DR forced 0; OE=1; no UNDERRUN.
  - When TRAIN falls, the current pattern word completes, then normal flow resumes.
- When undefined: no TRAIN port and no pattern logic. Behaviour is exactly as above.

Decomposition:
- Package o_serdes_pkg: state enum (IDLE, ACTIVE), beats(WIDTH, DDR_MODE) function, mode localparams.
- Sub-module o_ddr_cell: pos_q/neg_q flops plus phase mux with E and R. In SDR it is instantiated with neg flop disabled.

Test Plan:
- WIDTH=8, DDR: single word 8'hA5 -> Q per half-period 1,0,1,0,0,1,0,1 over 4 cycles. OE high for those 4 cycles. UNDERRUN pulse on the 5th posedge, then Q=0.
- Back-to-back 8'hA5, 8'h3C with DV held -> 16 contiguous bits (…,0,0,1,1,1,1,0,0). DR high once every 4 cycles. No UNDERRUN until the stream ends.
- E dropped for 3 cycles after the 2nd beat of 8'hF0 -> Q/OE frozen. The remaining 4 bits follow after E returns; total 8 bits correct.
- R pulsed mid-word -> Q=0, OE=0, DR=0 immediately. No UNDERRUN. The next word 8'h81 is serialized correctly.
- DDR_MODE=0, WIDTH=4, D=4'hC -> Q=0,0,1,1 for one full period each. DR every 4 cycles.
- TRAINING_EN defined, TRAIN=1 for 3 words -> Q repeats 1010... pattern. DR stays 0; DV ignored.
